// File: rtl/main_control_fsm_if.sv
// Memory-side handshake bundle between the main control FSM and the unified
// instruction/data memory port.
interface main_control_fsm_if;
    logic mem_req;
    logic mem_we;
    logic i_or_d;
    logic mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        output i_or_d,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  i_or_d,
        output mem_ready
    );
endinterface

// File: rtl/main_control_fsm.sv
// Multi-cycle RV32I main control: sequences fetch/decode/execute/memory/writeback
// for R-type, ADDI, LW, SW and BEQ; counts retired instructions, traps on illegal ones.
module main_control_fsm #(
    parameter int unsigned width_instruc = 32,
    parameter int unsigned CNT_W         = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     run,
    input  logic [width_instruc-1:0] instruccion,
    main_control_fsm_if.master       mem,
    output logic                     ir_write,
    output logic                     pc_write,
    output logic                     pc_write_cond,
    output logic                     pc_src,
    output logic [1:0]               alu_src_a,
    output logic [1:0]               alu_src_b,
    output logic [1:0]               ALU_OP,
    output logic                     reg_write,
    output logic                     mem_to_reg,
    output logic                     illegal,
    output logic [CNT_W-1:0]         instret
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_IMM_EXEC,
        S_ALU_WB,
        S_MEM_ADDR,
        S_MEM_READ,
        S_MEM_WB,
        S_MEM_WRITE,
        S_BRANCH,
        S_TRAP
    } state_t;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_IMM  = 7'b0010011;
    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;

    state_t state_q;
    state_t state_d;
    logic   retire;
    logic   mem_req_q;
    logic   mem_we_q;
    logic   i_or_d_q;
    logic   fetch_done;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       unused_instr_bits;

    assign opcode = instruccion[6:0];
    assign funct3 = instruccion[14:12];
    assign funct7 = instruccion[31:25];
    // Register/immediate fields belong to the datapath, not to control.
    assign unused_instr_bits = ^instruccion;

    function automatic state_t decode_target(input logic [6:0] op,
                                             input logic [2:0] f3,
                                             input logic [6:0] f7);
        case (op)
            OP_R: begin
                if ((f7 == 7'b0000000 && (f3 == 3'b000 || f3 == 3'b110 || f3 == 3'b111)) ||
                    (f7 == 7'b0100000 && f3 == 3'b000))
                    return S_EXECUTE;
                return S_TRAP;
            end
            OP_IMM:   return (f3 == 3'b000) ? S_IMM_EXEC : S_TRAP;
            OP_LOAD:  return (f3 == 3'b010) ? S_MEM_ADDR : S_TRAP;
            OP_STORE: return (f3 == 3'b010) ? S_MEM_ADDR : S_TRAP;
            OP_BR:    return (f3 == 3'b000) ? S_BRANCH   : S_TRAP;
            default:  return S_TRAP;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            S_IDLE:      if (run) state_d = S_FETCH;
            S_FETCH:     if (mem.mem_ready) state_d = S_DECODE;
            S_DECODE:    state_d = decode_target(opcode, funct3, funct7);
            S_EXECUTE:   state_d = S_ALU_WB;
            S_IMM_EXEC:  state_d = S_ALU_WB;
            S_ALU_WB:    retire  = 1'b1;
            S_MEM_ADDR:  state_d = (opcode == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  if (mem.mem_ready) state_d = S_MEM_WB;
            S_MEM_WB:    retire  = 1'b1;
            S_MEM_WRITE: if (mem.mem_ready) retire = 1'b1;
            S_BRANCH:    retire  = 1'b1;
            S_TRAP:      state_d = S_TRAP;
            default:     state_d = S_IDLE;
        endcase
        if (retire) state_d = run ? S_FETCH : S_IDLE;
    end

    // Moore outputs are registered by decoding the next state, so each output
    // register already holds the value for the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            instret       <= '0;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            i_or_d_q      <= 1'b0;
            pc_write_cond <= 1'b0;
            pc_src        <= 1'b0;
            alu_src_a     <= '0;
            alu_src_b     <= '0;
            ALU_OP        <= '0;
            reg_write     <= 1'b0;
            mem_to_reg    <= 1'b0;
            illegal       <= 1'b0;
        end else begin
            state_q <= state_d;
            if (retire) instret <= instret + CNT_W'(1);

            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            i_or_d_q      <= 1'b0;
            pc_write_cond <= 1'b0;
            pc_src        <= 1'b0;
            alu_src_a     <= 2'b00;
            alu_src_b     <= 2'b00;
            ALU_OP        <= 2'b00;
            reg_write     <= 1'b0;
            mem_to_reg    <= 1'b0;
            illegal       <= 1'b0;

            case (state_d)
                S_FETCH: begin
                    mem_req_q <= 1'b1;
                    alu_src_b <= 2'b01;
                end
                S_DECODE: begin
                    alu_src_a <= 2'b10;
                    alu_src_b <= 2'b10;
                end
                S_EXECUTE: begin
                    alu_src_a <= 2'b01;
                    ALU_OP    <= 2'b10;
                end
                S_IMM_EXEC, S_MEM_ADDR: begin
                    alu_src_a <= 2'b01;
                    alu_src_b <= 2'b10;
                end
                S_ALU_WB: reg_write <= 1'b1;
                S_MEM_READ: begin
                    mem_req_q <= 1'b1;
                    i_or_d_q  <= 1'b1;
                end
                S_MEM_WB: begin
                    reg_write  <= 1'b1;
                    mem_to_reg <= 1'b1;
                end
                S_MEM_WRITE: begin
                    mem_req_q <= 1'b1;
                    mem_we_q  <= 1'b1;
                    i_or_d_q  <= 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a     <= 2'b01;
                    ALU_OP        <= 2'b01;
                    pc_write_cond <= 1'b1;
                    pc_src        <= 1'b1;
                end
                S_TRAP:  illegal <= 1'b1;
                default: ;
            endcase
        end
    end

    // IR/PC loads must line up with the cycle the fetch data actually arrives.
    assign fetch_done = (state_q == S_FETCH) && mem.mem_ready;
    assign ir_write   = fetch_done;
    assign pc_write   = fetch_done;

    assign mem.mem_req = mem_req_q;
    assign mem.mem_we  = mem_we_q;
    assign mem.i_or_d  = i_or_d_q;

endmodule
